// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, the
// running decision, and the width helper for the bit index.
package cmp_pkg;

   typedef enum logic {
      IDLE,
      SCAN
   } state_e;

   typedef enum logic [1:0] {
      UNDEC = 2'b00,
      GT    = 2'b01,
      LT    = 2'b10
   } dec_e;

   // An index register narrower than one bit cannot be declared.
   function automatic int idx_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Request/response bundle of serial_mag_cmp: operands and start in, handshake
// and one-hot relation out.
interface serial_mag_cmp_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (output start, a, b, input busy, done, gt, eq, lt);
   modport slave  (input start, a, b, output busy, done, gt, eq, lt);

endinterface

// File: rtl/cmp_bit_cell.sv
// One left-to-right comparison step: folds a single bit pair into the running
// decision. Purely combinational.
module cmp_bit_cell
   import cmp_pkg::*;
(
   input  dec_e dec_i,
   input  logic a_i,
   input  logic b_i,
   input  logic msb_signed_i,
   output dec_e dec_o
);

   always_comb begin
      dec_o = dec_i;
      // On the two's-complement sign bit a set bit means negative, so the sense flips.
      if ((dec_i == UNDEC) && (a_i != b_i)) begin
         dec_o = (a_i ^ msb_signed_i) ? GT : LT;
      end
   end

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator, MSB first, one bit pair per clock.
// Build option SERIAL_MAG_CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_mag_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0
) (
   input logic             clk,
   input logic             rst_n,
   serial_mag_cmp_if.slave bus
);

   localparam int             IW      = idx_width(WIDTH);
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   state_e           state_q, state_d;
   dec_e             dec_q, dec_d, dec_step;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic             msb_signed;
   logic             finish;

   assign msb_signed = (SIGNED != 0) && (idx_q == IDX_MSB);

   cmp_bit_cell u_cell (
      .dec_i        (dec_q),
      .a_i          (a_q[idx_q]),
      .b_i          (b_q[idx_q]),
      .msb_signed_i (msb_signed),
      .dec_o        (dec_step)
   );

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
   assign finish = (idx_q == '0) || (dec_step != UNDEC);
`else
   assign finish = (idx_q == '0);
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d = state_q;
      dec_d   = dec_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               idx_d   = IDX_MSB;
               dec_d   = UNDEC;
               state_d = SCAN;
            end
         end
         SCAN: begin
            dec_d = dec_step;
            idx_d = idx_q - IW'(1);
            if (finish) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
               gt_d    = (dec_step == GT);
               eq_d    = (dec_step == UNDEC);
               lt_d    = (dec_step == LT);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dec_q   <= UNDEC;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   assign bus.busy = (state_q == SCAN);
   assign bus.done = done_q;
   assign bus.gt   = gt_q;
   assign bus.eq   = eq_q;
   assign bus.lt   = lt_q;

endmodule
